// File: rtl/harvard_dmem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : harvard_dmem_bridge
// Description : Bridges the CPU data port to a variable-latency data memory
//               with a wait-request handshake. Stalls the CPU through
//               cpu_clk_enable until each access completes, returns the
//               captured read word, flags misaligned accesses and, when the
//               DMEM_BRIDGE_TIMEOUT_EN macro is defined, aborts accesses the
//               memory never acknowledges.
// Ports       : clk, reset (async, active-low)
//               cpu_data_address/read/write/writedata  -> request from CPU
//               cpu_data_readdata, cpu_clk_enable      -> load data / stall
//               mem_address/read/write/writedata       -> request to memory
//               mem_readdata, mem_waitrequest          <- memory response
//               misaligned, timeout                    -> sticky error flags
// Config      : `define DMEM_BRIDGE_TIMEOUT_EN enables the watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module harvard_dmem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_READDATA   = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_data_address,
  input  logic        cpu_data_read,
  input  logic        cpu_data_write,
  input  logic [31:0] cpu_data_writedata,
  output logic [31:0] cpu_data_readdata,
  output logic        cpu_clk_enable,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest,
  output logic        misaligned,
  output logic        timeout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [31:0] mem_writedata_q, mem_writedata_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] readdata_q, readdata_d;
  logic        misaligned_q, misaligned_d;
  logic        w_req;
  logic        w_wd_expire;

  assign w_req = cpu_data_read | cpu_data_write;

`ifdef DMEM_BRIDGE_TIMEOUT_EN
  localparam int unsigned c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_cnt_w-1:0] wd_cnt_q, wd_cnt_d;
  logic               timeout_q, timeout_d;

  // The cycle in which the count would reach TIMEOUT_CYCLES is the abort cycle.
  assign w_wd_expire = (state_q == ACCESS) && mem_waitrequest &&
                       (wd_cnt_q == c_cnt_w'(TIMEOUT_CYCLES - 1));
  assign timeout     = timeout_q;
`else
  logic unused_params;

  assign unused_params = (^ERR_READDATA) ^ (TIMEOUT_CYCLES == 0);
  assign w_wd_expire   = 1'b0;
  assign timeout       = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    mem_address_d   = mem_address_q;
    mem_writedata_d = mem_writedata_q;
    mem_read_d      = mem_read_q;
    mem_write_d     = mem_write_q;
    readdata_d      = readdata_q;
    misaligned_d    = misaligned_q;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
    timeout_d       = timeout_q;
    // Counts only consecutive stalled ACCESS cycles; zero everywhere else.
    wd_cnt_d        = '0;
    if ((state_q == ACCESS) && mem_waitrequest && !w_wd_expire) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
`endif

    case (state_q)
      IDLE: begin
        if (w_req) begin
          mem_address_d   = cpu_data_address;
          mem_writedata_d = cpu_data_writedata;
          if (cpu_data_address[1:0] != 2'b00) begin
            // Memory is never touched; only a pure read clears the load data.
            misaligned_d = 1'b1;
            if (!cpu_data_write) begin
              readdata_d = 32'h0;
            end
            state_d = DONE;
          end else begin
            // A simultaneous read and write resolves to the write.
            mem_read_d  = !cpu_data_write;
            mem_write_d = cpu_data_write;
            state_d     = ACCESS;
          end
        end
      end

      ACCESS: begin
        if (!mem_waitrequest) begin
          if (mem_read_q) begin
            readdata_d = mem_readdata;
          end
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = DONE;
        end else if (w_wd_expire) begin
`ifdef DMEM_BRIDGE_TIMEOUT_EN
          timeout_d = 1'b1;
          if (mem_read_q) begin
            readdata_d = ERR_READDATA;
          end
`endif
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      mem_address_q   <= 32'h0;
      mem_writedata_q <= 32'h0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      readdata_q      <= 32'h0;
      misaligned_q    <= 1'b0;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
      timeout_q       <= 1'b0;
      wd_cnt_q        <= '0;
`endif
    end else begin
      state_q         <= state_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      readdata_q      <= readdata_d;
      misaligned_q    <= misaligned_d;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
      timeout_q       <= timeout_d;
      wd_cnt_q        <= wd_cnt_d;
`endif
    end
  end

  // Combinational in IDLE so the CPU is frozen in the very cycle it asks.
  always_comb begin
    cpu_clk_enable = 1'b0;
    case (state_q)
      IDLE:    cpu_clk_enable = !w_req;
      DONE:    cpu_clk_enable = 1'b1;
      default: cpu_clk_enable = 1'b0;
    endcase
  end

  assign cpu_data_readdata = readdata_q;
  assign mem_address       = mem_address_q;
  assign mem_writedata     = mem_writedata_q;
  assign mem_read          = mem_read_q;
  assign mem_write         = mem_write_q;
  assign misaligned        = misaligned_q;

endmodule
`default_nettype wire

// File: tb/tb_harvard_dmem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_harvard_dmem_bridge
// Description : Self-checking bench for harvard_dmem_bridge. A transaction
//               model derives the per-cycle expected outputs of each CPU
//               access; one negedge process compares them against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_harvard_dmem_bridge;

  localparam int unsigned T   = 4;
  localparam logic [31:0] ERR = 32'hFFFF_FFFF;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] cpu_data_address = 32'h0;
  logic        cpu_data_read = 1'b0;
  logic        cpu_data_write = 1'b0;
  logic [31:0] cpu_data_writedata = 32'h0;
  logic [31:0] cpu_data_readdata;
  logic        cpu_clk_enable;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = 32'h0;
  logic        mem_waitrequest = 1'b1;
  logic        misaligned;
  logic        timeout;

  harvard_dmem_bridge #(
    .TIMEOUT_CYCLES (T),
    .ERR_READDATA   (ERR)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .cpu_data_address   (cpu_data_address),
    .cpu_data_read      (cpu_data_read),
    .cpu_data_write     (cpu_data_write),
    .cpu_data_writedata (cpu_data_writedata),
    .cpu_data_readdata  (cpu_data_readdata),
    .cpu_clk_enable     (cpu_clk_enable),
    .mem_address        (mem_address),
    .mem_read           (mem_read),
    .mem_write          (mem_write),
    .mem_writedata      (mem_writedata),
    .mem_readdata       (mem_readdata),
    .mem_waitrequest    (mem_waitrequest),
    .misaligned         (misaligned),
    .timeout            (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        clk_en;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mis;
    logic        to;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  int          n_cmp = 0;
  int          n_err = 0;
  int          stall_cnt = 0;
  int          strobe_cnt = 0;

  // Architectural state of the model.
  logic [31:0] model_rdata = 32'h0;
  logic        model_mis = 1'b0;
  logic        model_to = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cyc(input logic ce, input logic rd, input logic wr,
                            input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    e.clk_en = ce;
    e.rd     = rd;
    e.wr     = wr;
    e.addr   = a;
    e.wdata  = wd;
    e.rdata  = model_rdata;
    e.mis    = model_mis;
    e.to     = model_to;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      chk("clk_enable", {31'h0, cpu_clk_enable}, {31'h0, cur.clk_en});
      chk("mem_read",   {31'h0, mem_read},       {31'h0, cur.rd});
      chk("mem_write",  {31'h0, mem_write},      {31'h0, cur.wr});
      chk("readdata",   cpu_data_readdata,       cur.rdata);
      chk("misaligned", {31'h0, misaligned},     {31'h0, cur.mis});
      chk("timeout",    {31'h0, timeout},        {31'h0, cur.to});
      if (cur.rd || cur.wr) chk("mem_address", mem_address, cur.addr);
      if (cur.wr)           chk("mem_writedata", mem_writedata, cur.wdata);
      if (!cpu_clk_enable)      stall_cnt++;
      if (mem_read || mem_write) strobe_cnt++;
    end
  end

  // One CPU access: the memory answers after nwait stalled cycles.
  task automatic txn(input logic [31:0] addr, input logic rd, input logic wr,
                     input logic [31:0] wdata, input int nwait, input logic [31:0] rdata);
    bit mis   = (addr[1:0] != 2'b00);
    bit is_wr = wr;
    bit abort = 1'b0;
    int acc   = nwait + 1;
    if (TO_EN && nwait >= int'(T)) begin
      acc   = T;
      abort = 1'b1;
    end
    cpu_data_address   = addr;
    cpu_data_read      = rd;
    cpu_data_write     = wr;
    cpu_data_writedata = wdata;
    mem_waitrequest    = 1'b1;
    mem_readdata       = ~rdata;
    expect_cyc(1'b0, 1'b0, 1'b0, addr, wdata);
    step();
    if (!mis) begin
      for (int k = 0; k < acc; k++) begin
        mem_waitrequest = (k < nwait);
        mem_readdata    = (k < nwait) ? ~rdata : rdata;
        expect_cyc(1'b0, !is_wr, is_wr, addr, wdata);
        step();
      end
    end
    if (mis) begin
      model_mis = 1'b1;
      if (!is_wr) model_rdata = 32'h0;
    end else if (abort) begin
      model_to = 1'b1;
      if (!is_wr) model_rdata = ERR;
    end else if (!is_wr) begin
      model_rdata = rdata;
    end
    mem_waitrequest = 1'b1;
    mem_readdata    = 32'hDEAD_0000;
    expect_cyc(1'b1, 1'b0, 1'b0, addr, wdata);
    step();
  endtask

  task automatic idle(input int n);
    cpu_data_read  = 1'b0;
    cpu_data_write = 1'b0;
    for (int k = 0; k < n; k++) begin
      expect_cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    // Reset state
    reset = 1'b0;
    step();
    step();
    chk("rst_mem_read",   {31'h0, mem_read},       32'h0);
    chk("rst_mem_write",  {31'h0, mem_write},      32'h0);
    chk("rst_mem_addr",   mem_address,             32'h0);
    chk("rst_mem_wdata",  mem_writedata,           32'h0);
    chk("rst_readdata",   cpu_data_readdata,       32'h0);
    chk("rst_misaligned", {31'h0, misaligned},     32'h0);
    chk("rst_timeout",    {31'h0, timeout},        32'h0);
    chk("rst_clk_enable", {31'h0, cpu_clk_enable}, 32'h1);
    reset = 1'b1;
    idle(2);

    // Zero-wait read
    stall_cnt = 0;
    txn(32'h0000_0010, 1'b1, 1'b0, 32'h0, 0, 32'hCAFE_BABE);
    idle(1);
    chk("t1_stall_cycles", stall_cnt, 2);
    chk("t1_readdata", cpu_data_readdata, 32'hCAFE_BABE);

    // Write with three wait cycles
    strobe_cnt = 0;
    txn(32'h0000_0020, 1'b0, 1'b1, 32'h1234_5678, 3, 32'h0);
    idle(1);
    chk("t2_write_cycles", strobe_cnt, 4);
    chk("t2_readdata_kept", cpu_data_readdata, 32'hCAFE_BABE);

    // Read and write together: write wins, load data untouched
    strobe_cnt = 0;
    txn(32'h0000_0040, 1'b1, 1'b1, 32'hA5A5_5A5A, 1, 32'h1111_2222);
    idle(1);
    chk("t6_strobe_cycles", strobe_cnt, 2);
    chk("t6_readdata", cpu_data_readdata, 32'hCAFE_BABE);

    // Misaligned read
    stall_cnt  = 0;
    strobe_cnt = 0;
    txn(32'h0000_0013, 1'b1, 1'b0, 32'h0, 0, 32'h7777_7777);
    idle(1);
    chk("t3_stall_cycles", stall_cnt, 1);
    chk("t3_strobes", strobe_cnt, 0);
    chk("t3_misaligned", {31'h0, misaligned}, 32'h1);
    chk("t3_readdata", cpu_data_readdata, 32'h0);

    // Back-to-back reads with differing latency
    txn(32'h0000_0100, 1'b1, 1'b0, 32'h0, 2, 32'h0BAD_F00D);
    txn(32'h0000_0104, 1'b1, 1'b0, 32'h0, 0, 32'h1357_9BDF);
    idle(1);
    chk("b2b_readdata", cpu_data_readdata, 32'h1357_9BDF);

    // Memory that stalls well past the watchdog limit
    strobe_cnt = 0;
    txn(32'h0000_0200, 1'b1, 1'b0, 32'h0, 6, 32'h2468_ACE0);
    idle(1);
`ifdef DMEM_BRIDGE_TIMEOUT_EN
    chk("t5_read_cycles", strobe_cnt, 4);
    chk("t5_timeout", {31'h0, timeout}, 32'h1);
    chk("t5_readdata", cpu_data_readdata, 32'hFFFF_FFFF);
`else
    chk("t5_read_cycles", strobe_cnt, 7);
    chk("t5_timeout", {31'h0, timeout}, 32'h0);
    chk("t5_readdata", cpu_data_readdata, 32'h2468_ACE0);
`endif

    // Asynchronous reset in the middle of a stalled read
    cpu_data_address = 32'h0000_0080;
    cpu_data_read    = 1'b1;
    mem_waitrequest  = 1'b1;
    expect_cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    expect_cyc(1'b0, 1'b1, 1'b0, 32'h0000_0080, 32'h0);
    step();
    cpu_data_read = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("t4_mem_read", {31'h0, mem_read}, 32'h0);
    chk("t4_clk_enable", {31'h0, cpu_clk_enable}, 32'h1);
    chk("t4_misaligned", {31'h0, misaligned}, 32'h0);
    chk("t4_timeout", {31'h0, timeout}, 32'h0);
    chk("t4_readdata", cpu_data_readdata, 32'h0);
    step();
    step();
    chk("t4_no_strobe", {31'h0, mem_read | mem_write}, 32'h0);
    reset       = 1'b1;
    model_rdata = 32'h0;
    model_mis   = 1'b0;
    model_to    = 1'b0;
    idle(1);

    // Recovery after reset
    txn(32'h0000_0084, 1'b1, 1'b0, 32'h0, 1, 32'h600D_CAFE);
    idle(2);
    chk("post_rst_readdata", cpu_data_readdata, 32'h600D_CAFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
